// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program buffer that issues a stored instruction stream, one word per cycle
module instr_fetch_unit #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int IW    = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_wr_en,
  input  logic [AW-1:0] prog_wr_addr,
  input  logic [IW-1:0] prog_wr_data,
  output logic          prog_wr_ack,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stall,
  input  logic          abort,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issue_count,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);
  state_t        state, state_nx;
  logic [IW-1:0] mem [DEPTH];
  logic [AW:0]   len, len_nx, issue_count_nx;
  logic [AW-1:0] pc_nx, pc_inc;
  logic [IW-1:0] instruction_nx;
  logic          instr_valid_nx, busy_nx, done_nx, last, idle_or_done;
  assign idle_or_done = state != RUN;
  assign pc_inc       = pc + PC_ONE;
  assign last         = {1'b0, pc} == len - CNT_ONE;
  // program buffer write port; no reset so contents survive across runs
  always_ff @(posedge clk)
    if (prog_wr_en && idle_or_done) mem[prog_wr_addr] <= prog_wr_data;
  // next state and next registered outputs; mem reads see pre-write contents
  always_comb begin
    state_nx       = state;
    len_nx         = len;
    pc_nx          = pc;
    instruction_nx = instruction;
    instr_valid_nx = instr_valid;
    issue_count_nx = issue_count;
    busy_nx        = busy;
    done_nx        = done;
    if (idle_or_done) begin
      if (start) begin
        len_nx         = prog_len > LEN_MAX ? LEN_MAX : prog_len;
        pc_nx          = '0;
        issue_count_nx = '0;
        state_nx       = prog_len == '0 ? DONE : RUN;
        done_nx        = prog_len == '0;
        instr_valid_nx = prog_len != '0;
        busy_nx        = prog_len != '0;
        instruction_nx = prog_len == '0 ? '0 : mem[0];
      end
    end else if (abort) begin
      state_nx       = IDLE;
      instr_valid_nx = 1'b0;
      instruction_nx = '0;
      busy_nx        = 1'b0;
    end else if (!stall) begin
      issue_count_nx = issue_count + CNT_ONE;
      state_nx       = last ? DONE : RUN;
      pc_nx          = last ? pc : pc_inc;
      instruction_nx = last ? '0 : mem[pc_inc];
      instr_valid_nx = !last;
      busy_nx        = !last;
      done_nx        = last;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // registered outputs and run length
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      len         <= '0;
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      issue_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      prog_wr_ack <= 1'b0;
    end else begin
      len         <= len_nx;
      pc          <= pc_nx;
      instruction <= instruction_nx;
      instr_valid <= instr_valid_nx;
      issue_count <= issue_count_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      prog_wr_ack <= prog_wr_en && idle_or_done;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus random checks of instr_fetch_unit against a cycle model
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en, start, stall, abort;
  logic [5:0]  wr_addr;
  logic [12:0] wr_data;
  logic [6:0]  plen;
  logic        prog_wr_ack, instr_valid, busy, done;
  logic [12:0] instruction;
  logic [5:0]  pc;
  logic [6:0]  issue_count;
  logic [12:0] mm [64];
  logic [12:0] prog [4];
  logic [12:0] m_instr, saved;
  bit          m_run, m_done, m_valid, m_ack;
  int          m_pc, m_len, m_cnt;
  int          checks = 0, errors = 0;
  int          n1, v1, n2, v2;
  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .prog_wr_en(wr_en), .prog_wr_addr(wr_addr), .prog_wr_data(wr_data), .prog_wr_ack(prog_wr_ack),
    .prog_len(plen), .start(start), .stall(stall), .abort(abort),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .issue_count(issue_count), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_run = 0; m_done = 0; m_valid = 0; m_ack = 0;
    m_pc = 0; m_cnt = 0; m_len = 0; m_instr = '0;
  endtask
  task automatic model_edge();
    logic [12:0] e0;
    if (!rst) begin
      model_reset();
      return;
    end
    e0 = mm[0];
    m_ack = 0;
    if (!m_run) begin
      m_ack = wr_en;
      if (start) begin
        m_len = plen > 64 ? 64 : int'(plen);
        m_pc = 0; m_cnt = 0;
        m_run = m_len != 0;
        m_done = m_len == 0;
        m_valid = m_run;
        m_instr = m_run ? e0 : 13'h0;
      end
      if (wr_en) mm[wr_addr] = wr_data;
    end else if (abort) begin
      m_run = 0; m_valid = 0; m_instr = '0;
    end else if (!stall) begin
      m_cnt++;
      if (m_pc == m_len - 1) begin
        m_run = 0; m_valid = 0; m_instr = '0; m_done = 1;
      end else begin
        m_pc++;
        m_instr = mm[m_pc];
      end
    end
  endtask
  task automatic check_all();
    chk("instruction", instruction, m_instr);
    chk("instr_valid", instr_valid, m_valid);
    chk("pc", pc, m_pc);
    chk("issue_count", issue_count, m_cnt);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("prog_wr_ack", prog_wr_ack, m_ack);
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask
  task automatic idle_in();
    wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; stall = 0; abort = 0;
  endtask
  task automatic wait_done(output int n, output int v);
    n = 0; v = 0;
    while (!done && n < 200) begin
      if (instr_valid) v++;
      tick();
      n++;
    end
    chk("done_within_bound", done, 1);
  endtask
  initial begin
    idle_in();
    plen = '0;
    prog[0] = 13'h0200; prog[1] = 13'h0A10; prog[2] = 13'h1405; prog[3] = 13'h1E07;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = 6'(i); wr_data = prog[i];
      tick();
    end
    idle_in();
    tick();
    // plain run of four
    plen = 7'd4; start = 1;
    tick();
    start = 0;
    chk("run1_first", instruction, 13'h0200);
    wait_done(n1, v1);
    chk("run1_valid_cycles", v1, 4);
    chk("run1_count", issue_count, 4);
    chk("run1_busy", busy, 0);
    // stall three cycles at pc=1
    start = 1;
    tick();
    start = 0;
    tick();
    chk("stall_pc", pc, 1);
    stall = 1;
    repeat (3) tick();
    chk("stall_hold_instr", instruction, 13'h0A10);
    chk("stall_hold_count", issue_count, 1);
    stall = 0;
    wait_done(n2, v2);
    chk("stall_delay", 4 + n2, n1 + 3);
    chk("stall_count", issue_count, 4);
    // abort at pc=2
    start = 1;
    tick();
    start = 0;
    repeat (2) tick();
    chk("abort_pc", pc, 2);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_valid", instr_valid, 0);
    chk("abort_count", issue_count, 2);
    chk("abort_done", done, 0);
    tick();
    start = 1;
    tick();
    start = 0;
    chk("rerun_pc", pc, 0);
    chk("rerun_instr", instruction, 13'h0200);
    wait_done(n1, v1);
    // zero-length run
    plen = '0; start = 1;
    tick();
    start = 0;
    chk("len0_done", done, 1);
    chk("len0_valid", instr_valid, 0);
    tick();
    // full buffer, then exact and clamped length
    for (int i = 0; i < 64; i++) begin
      wr_en = 1; wr_addr = 6'(i); wr_data = 13'($urandom);
      tick();
    end
    idle_in();
    for (int k = 0; k < 2; k++) begin
      plen = k == 0 ? 7'd64 : 7'd100; start = 1;
      tick();
      start = 0;
      wait_done(n1, v1);
      chk("full_valid_cycles", v1, 64);
      chk("full_last_pc", pc, 63);
      chk("full_count", issue_count, 64);
    end
    // write and start during a run are ignored
    saved = mm[1];
    plen = 7'd4; start = 1;
    tick();
    start = 0;
    tick();
    wr_en = 1; wr_addr = 6'd1; wr_data = ~saved; start = 1;
    tick();
    idle_in();
    chk("run_wr_ack", prog_wr_ack, 0);
    chk("run_no_restart", pc, 2);
    wait_done(n1, v1);
    start = 1;
    tick();
    start = 0;
    tick();
    chk("readback", instruction, saved);
    wait_done(n1, v1);
    // asynchronous reset in the middle of a run
    plen = 7'd10; start = 1;
    tick();
    start = 0;
    tick();
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    rst = 1'b1;
    tick();
    chk("post_reset_busy", busy, 0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      wr_en = $urandom_range(0, 9) == 0;
      wr_addr = 6'($urandom);
      wr_data = 13'($urandom);
      start = $urandom_range(0, 7) == 0;
      stall = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 49) == 0;
      plen = $urandom_range(0, 7) == 0 ? 7'($urandom_range(60, 127)) : 7'($urandom_range(0, 12));
      tick();
    end
    idle_in();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
